// File: rtl/lc3_pkg.sv
// Shared LC-3 decode definitions: opcode values, decode FSM states and field helpers.
package lc3_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef enum logic [2:0] {
        S_RESET_IDLE = 3'd0,
        S_REQ        = 3'd1,
        S_WAIT       = 3'd2,
        S_ISSUE      = 3'd3,
        S_HALT       = 3'd4
    } state_t;

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

endpackage

// File: rtl/lc3_field_split.sv
// Purely combinational split of an LC-3 instruction word into decoded fields.
module lc3_field_split
    import lc3_pkg::*;
(
    input  logic [15:0] ir,
    output logic [3:0]  opcode,
    output logic [2:0]  dr,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2,
    output logic        imm_mode,
    output logic [15:0] imm5,
    output logic [8:0]  offset,
    output logic [2:0]  br_nzp,
    output logic        illegal
);

    assign opcode   = ir[15:12];
    assign dr       = ir[11:9];
    assign sr1      = ir[8:6];
    assign sr2      = ir[2:0];
    assign imm_mode = ir[5];
    assign imm5     = sext5(ir[4:0]);
    assign offset   = ir[8:0];
    // nzp passed through verbatim, including the never-taken 3'b000 case
    assign br_nzp   = (ir[15:12] == OP_BR) ? ir[11:9] : 3'b000;
    assign illegal  = (ir[15:12] == OP_RES) || (ir[15:12] == OP_RTI);

endmodule

// File: rtl/lc3_decode.sv
// LC-3 decode stage: requests an instruction, registers its split fields, issues
// them to execute under valid/ready, and stops fetching after the halt TRAP.
module lc3_decode
    import lc3_pkg::*;
#(
    parameter logic [7:0] HALT_VEC = 8'h25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_in,
    input  logic        exec_ready,
    output logic        fetch_start,
    output logic        instr_ready,
    output logic        dec_valid,
    output logic [3:0]  opCode_out,
    output logic [2:0]  dr_out,
    output logic [2:0]  sr1_out,
    output logic [2:0]  sr2_out,
    output logic        imm_mode,
    output logic [15:0] imm5_out,
    output logic [8:0]  offset_out,
    output logic [2:0]  br_nzp,
    output logic [15:0] pc_out,
    output logic        illegal,
    output logic        halted
);

    state_t state_q, state_d;

    logic [3:0]  f_opcode;
    logic [2:0]  f_dr, f_sr1, f_sr2, f_nzp;
    logic        f_imm_mode, f_illegal;
    logic [15:0] f_imm5;
    logic [8:0]  f_offset;
    logic        capture;
    logic        is_halt;

    lc3_field_split u_split (
        .ir       (instr_in),
        .opcode   (f_opcode),
        .dr       (f_dr),
        .sr1      (f_sr1),
        .sr2      (f_sr2),
        .imm_mode (f_imm_mode),
        .imm5     (f_imm5),
        .offset   (f_offset),
        .br_nzp   (f_nzp),
        .illegal  (f_illegal)
    );

    assign capture = (state_q == S_WAIT) && instr_valid;
    // The registered fields are the IR; offset_out[7:0] holds the trap vector.
    assign is_halt = (opCode_out == OP_TRAP) && (offset_out[7:0] == HALT_VEC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET_IDLE: state_d = S_REQ;
            S_REQ:        state_d = S_WAIT;
            S_WAIT:       if (instr_valid) state_d = S_ISSUE;
            S_ISSUE:      if (exec_ready)  state_d = is_halt ? S_HALT : S_REQ;
            S_HALT:       state_d = S_HALT;
            default:      state_d = S_RESET_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opCode_out <= '0;
            dr_out     <= '0;
            sr1_out    <= '0;
            sr2_out    <= '0;
            imm_mode   <= 1'b0;
            imm5_out   <= '0;
            offset_out <= '0;
            br_nzp     <= '0;
            pc_out     <= '0;
            illegal    <= 1'b0;
        end else if (capture) begin
            opCode_out <= f_opcode;
            dr_out     <= f_dr;
            sr1_out    <= f_sr1;
            sr2_out    <= f_sr2;
            imm_mode   <= f_imm_mode;
            imm5_out   <= f_imm5;
            offset_out <= f_offset;
            br_nzp     <= f_nzp;
            pc_out     <= pc_in;
            illegal    <= f_illegal;
        end
    end

    assign fetch_start = (state_q == S_REQ);
    assign instr_ready = (state_q == S_WAIT);
    assign dec_valid   = (state_q == S_ISSUE);
    assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_lc3_decode.sv
// Directed bench for lc3_decode with a field-level reference model and per-cycle compare.
module tb_lc3_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr_in = '0;
    logic [15:0] pc_in = '0;
    logic        exec_ready = 1'b0;
    logic        fetch_start, instr_ready, dec_valid;
    logic [3:0]  opCode_out;
    logic [2:0]  dr_out, sr1_out, sr2_out, br_nzp;
    logic        imm_mode, illegal, halted;
    logic [15:0] imm5_out, pc_out;
    logic [8:0]  offset_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] cur_instr = '0;
    logic [15:0] cur_pc    = '0;

    lc3_decode #(.HALT_VEC(8'h25)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_in(instr_in),
        .pc_in(pc_in), .exec_ready(exec_ready), .fetch_start(fetch_start),
        .instr_ready(instr_ready), .dec_valid(dec_valid), .opCode_out(opCode_out),
        .dr_out(dr_out), .sr1_out(sr1_out), .sr2_out(sr2_out), .imm_mode(imm_mode),
        .imm5_out(imm5_out), .offset_out(offset_out), .br_nzp(br_nzp),
        .pc_out(pc_out), .illegal(illegal), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the decoded bundle an LC-3 instruction word must produce.
    function automatic logic [63:0] model_bundle(input logic [15:0] w, input logic [15:0] pc);
        int op, v;
        logic [15:0] imm;
        logic [2:0]  nzp;
        logic        ill;
        op  = int'(w) / 4096;
        v   = int'(w) % 32;
        if (v >= 16) v = v - 32;
        imm = 16'(v);
        nzp = (op == 0) ? 3'((int'(w) / 512) % 8) : 3'd0;
        ill = (op == 8) || (op == 13);
        return {4'(op), 3'((int'(w) / 512) % 8), 3'((int'(w) / 64) % 8), 3'(int'(w) % 8),
                1'((int'(w) / 32) % 2), imm, 9'(int'(w) % 512), nzp, pc, ill};
    endfunction

    logic [63:0] dut_bundle;
    assign dut_bundle = {opCode_out, dr_out, sr1_out, sr2_out, imm_mode, imm5_out,
                         offset_out, br_nzp, pc_out, illegal};

    always @(negedge clk) begin
        if (!rst) begin
            if (dec_valid) check("bundle", dut_bundle, model_bundle(cur_instr, cur_pc));
            if (halted) check("halt_no_fetch", {fetch_start, dec_valid}, 2'b00);
        end
    end

    task automatic release_reset();
        rst = 1'b0;
        @(negedge clk);
        check("req_pulse", {fetch_start, instr_ready, dec_valid}, 3'b100);
        @(negedge clk);
        check("wait_state", {fetch_start, instr_ready, dec_valid}, 3'b010);
    endtask

    // Called at a negedge in WAIT; leaves the bench at the first ISSUE negedge.
    task automatic send(input logic [15:0] w, input logic [15:0] pc);
        instr_valid = 1'b1;
        instr_in    = w;
        pc_in       = pc;
        cur_instr   = w;
        cur_pc      = pc;
        @(negedge clk);
        instr_valid = 1'b0;
        instr_in    = 16'hBEEF;
        pc_in       = 16'hDEAD;
        check("issue_latency", {dec_valid, instr_ready, fetch_start}, 3'b100);
    endtask

    // Called in ISSUE; holds exec_ready low, then accepts, landing in REQ (or HALT).
    task automatic accept(input int hold, input logic to_halt);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_issue", {dec_valid, fetch_start}, 2'b10);
        end
        exec_ready = 1'b1;
        @(negedge clk);
        exec_ready = 1'b0;
        if (to_halt) begin
            check("halt_enter", {halted, dec_valid, fetch_start}, 3'b100);
        end else begin
            check("next_req", {fetch_start, dec_valid}, 2'b10);
            @(negedge clk);
            check("next_wait", instr_ready, 1'b1);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs", {fetch_start, instr_ready, dec_valid, halted, dut_bundle},
              {4'b0, 64'b0});
        release_reset();

        // ADD 0x12BF
        send(16'h12BF, 16'h3000);
        check("add_fields", {opCode_out, dr_out, sr1_out, imm_mode, imm5_out, br_nzp},
              {4'b0001, 3'd1, 3'd2, 1'b1, 16'hFFFF, 3'b000});
        accept(0, 1'b0);

        // ST 0x3605 held three cycles
        send(16'h3605, 16'h3000);
        check("st_fields", {opCode_out, dr_out, offset_out, pc_out},
              {4'b0011, 3'd3, 9'h005, 16'h3000});
        accept(3, 1'b0);

        // BR 0x0E03, with instr_valid also high at the accept edge (must not capture)
        send(16'h0E03, 16'h3001);
        check("br_fields", {br_nzp, offset_out}, {3'b111, 9'h003});
        instr_valid = 1'b1;
        instr_in    = 16'h1234;
        exec_ready  = 1'b1;
        @(negedge clk);
        exec_ready  = 1'b0;
        instr_valid = 1'b0;
        check("no_capture_in_issue", {fetch_start, opCode_out, br_nzp}, {1'b1, 4'b0000, 3'b111});
        @(negedge clk);
        check("next_wait2", instr_ready, 1'b1);

        // BR never-taken nzp stays 000; exec_ready high before dec_valid has no effect
        exec_ready = 1'b1;
        @(negedge clk);
        check("early_ready", {instr_ready, dec_valid}, 2'b10);
        exec_ready = 1'b0;
        send(16'h0005, 16'h3002);
        check("br_never", br_nzp, 3'b000);
        accept(1, 1'b0);

        // Reserved and RTI issue normally with illegal set
        send(16'hD000, 16'h3003);
        check("res_illegal", {illegal, dec_valid}, 2'b11);
        accept(0, 1'b0);
        send(16'h8000, 16'h3004);
        check("rti_illegal", illegal, 1'b1);
        accept(0, 1'b0);

        // TRAP with a different vector does not halt
        send(16'hF023, 16'h3005);
        accept(0, 1'b0);

        // TRAP x25 halts; nothing further for 20 cycles
        send(16'hF025, 16'h3006);
        accept(0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            instr_valid = 1'b1;
            exec_ready  = 1'b1;
            @(negedge clk);
            check("halt_sticky", {halted, fetch_start, instr_ready}, 3'b100);
        end
        instr_valid = 1'b0;
        exec_ready  = 1'b0;

        rst = 1'b1;
        @(negedge clk);
        check("halt_reset", {halted, fetch_start}, 2'b00);
        release_reset();

        // Reset pulsed mid-ISSUE
        send(16'h5020, 16'h4000);
        #1 rst = 1'b1;
        #1 check("async_drop", {dec_valid, fetch_start, instr_ready, dut_bundle},
                 {3'b000, 64'b0});
        @(negedge clk);
        release_reset();
        send(16'h1E3F, 16'h4001);
        accept(0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
